obi_interconnect: RTL and testbench
===================================

Name: obi_interconnect

Overview:
Parametrised N-master x M-slave OBI interconnect that replaces the fixed two-port instruction/data arbiter and hard-coded address mux in the SoC top. It round-robin arbitrates between masters, decodes a configurable address field to one of M slave ports, and keeps one transaction outstanding. Unmapped accesses and slave response timeouts complete with an error response instead of hanging the core.

Parameters:
NUM_MASTERS, 2, number of OBI master ports (1..8)
NUM_SLAVES, 4, number of OBI slave ports (1..16)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
SEL_MSB, 31, MSB of the address decode field
SEL_LSB, 24, LSB of the address decode field; SW = SEL_MSB-SEL_LSB+1
SLAVE_BASES, {8'hF,8'hE,8'hA,8'h0}, NUM_SLAVES*SW bits; slice i is the decode value for slave i; lowest matching index wins
TIMEOUT_CYCLES, 255, cycles allowed in RESP before error completion; 0 disables the timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  NUM_MASTERS  per-master request
m_gnt_o  out  NUM_MASTERS  per-master grant
m_addr_i  in  NUM_MASTERS*ADDR_WIDTH  packed addresses, master i at slice i
m_we_i  in  NUM_MASTERS  write enable
m_be_i  in  NUM_MASTERS*DATA_WIDTH/8  byte enables
m_wdata_i  in  NUM_MASTERS*DATA_WIDTH  write data
m_rvalid_o  out  NUM_MASTERS  response valid
m_rdata_o  out  DATA_WIDTH  shared read data; valid only with the owner's rvalid
m_err_o  out  1  error flag; qualified by m_rvalid_o
s_req_o  out  NUM_SLAVES  per-slave request
s_gnt_i  in  NUM_SLAVES  per-slave grant
s_addr_o, s_we_o, s_be_o, s_wdata_o  out  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  shared request payload
s_rvalid_i  in  NUM_SLAVES  per-slave response valid
s_rdata_i  in  NUM_SLAVES*DATA_WIDTH  packed read data
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, rst_ni low): state=IDLE, last_grant=NUM_MASTERS-1 so master 0 wins first, timeout counter=0. All outputs 0, including s_addr_o, s_be_o, s_wdata_o and m_rdata_o.
- FSM states: IDLE, ADDR, RESP, ERR.
- IDLE:
  - If any m_req_i is high, choose the first requesting master at or after last_grant+1, modulo NUM_MASTERS.
  - Register the chosen master as owner.
  - Register the decoded slave index, or a miss flag when no slave matches.
  - Next state is ADDR on a hit, ERR on a miss.
  - No outputs are asserted in IDLE.
- ADDR:
  - s_req_o[sel] = m_req_i[owner]; the payload comes combinationally from the owner's slices.
  - m_gnt_o[owner] = s_gnt_i[sel].
  - When s_req and s_gnt are both high, move to RESP and clear the counter.
  - If the owner drops its request before grant (an OBI violation), return to IDLE with no response.
- RESP:
  - s_req_o is all zeros.
  - m_rvalid_o[owner] = s_rvalid_i[sel], and m_rdata_o = s_rdata_i[sel] in the same cycle; m_err_o = 0.
  - On rvalid: go to IDLE and set last_grant=owner.
  - The counter increments every cycle. When it reaches TIMEOUT_CYCLES (if nonzero), drive rvalid=1, err=1, rdata=0 to the owner for one cycle, go to IDLE and set last_grant=owner.
- ERR:
  - Cycle 1: m_gnt_o[owner]=1.
  - Cycle 2: m_rvalid_o[owner]=1, m_err_o=1, m_rdata_o=0; then go to IDLE and set last_grant=owner.
  - Unmapped writes have no side effect.
- Latency:
  - Arbitration takes one cycle (IDLE to ADDR).
  - For a slave that grants in the same cycle it is requested, the earliest grant is cycle 1 after the master request is sampled and the earliest rvalid is cycle 2.
  - Back-to-back transactions have one IDLE bubble between them.
- Responses from non-selected slaves are ignored. s_rvalid_i is ignored outside RESP, so a late response after a timeout is dropped.
- One transaction is outstanding at a time. A new grant is never issued before the previous response completes.
- A master's request arriving while another master owns the bus waits; priority is re-evaluated only in IDLE.
- Reset asserted mid-transaction forces IDLE immediately; the pending transaction is abandoned.

Test Plan:
- Single read: 2 masters. Master 0 reads 0x0000_0010; slave 0 grants in the same cycle and returns rvalid one cycle later with rdata 0x1234_5678. -> m_gnt_o[0] at cycle 1, m_rvalid_o[0] at cycle 2, m_rdata_o=0x1234_5678, m_err_o=0.
- Round-robin: m_req_i=2'b11 held continuously; each master issues 4 reads. -> grants alternate 0,1,0,1,... and no master waits more than one transaction.
- Decode: writes to 0x0A00_0000 and 0xF000_0004 with wdata 0xCAFE. -> only s_req_o[2], then only s_req_o[3], are asserted, with s_wdata_o=0xCAFE.
- Unmapped access: read 0x5000_0000. -> no s_req_o asserted; gnt, then the next cycle rvalid with err=1 and rdata=0.
- Timeout: TIMEOUT_CYCLES=8; the slave grants but never returns rvalid. -> exactly 8 cycles into RESP the owner sees rvalid+err; a later slave rvalid is ignored and the next transaction completes normally.
- Reset mid-RESP: pulse rst_ni low. -> all outputs 0 asynchronously, busy_o=0, and after release master 0 wins the first arbitration.

Source files
------------

// File: rtl/obi_interconnect.sv
// N-master x M-slave OBI interconnect: round-robin arbitration, address-field decode,
// a single outstanding transaction, and error completion for unmapped or timed-out accesses.
module obi_interconnect #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SEL_MSB        = 31,
    parameter int unsigned SEL_LSB        = 24,
    parameter logic [NUM_SLAVES*(SEL_MSB-SEL_LSB+1)-1:0] SLAVE_BASES = {8'hF, 8'hE, 8'hA, 8'h0},
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_MASTERS-1:0]              m_req_i,
    output logic [NUM_MASTERS-1:0]              m_gnt_o,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [NUM_MASTERS-1:0]              m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata_i,
    output logic [NUM_MASTERS-1:0]              m_rvalid_o,
    output logic [DATA_WIDTH-1:0]               m_rdata_o,
    output logic                                m_err_o,
    output logic [NUM_SLAVES-1:0]               s_req_o,
    input  logic [NUM_SLAVES-1:0]               s_gnt_i,
    output logic [ADDR_WIDTH-1:0]               s_addr_o,
    output logic                                s_we_o,
    output logic [DATA_WIDTH/8-1:0]             s_be_o,
    output logic [DATA_WIDTH-1:0]               s_wdata_o,
    input  logic [NUM_SLAVES-1:0]               s_rvalid_i,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]    s_rdata_i,
    output logic                                busy_o
);

    localparam int unsigned BW  = DATA_WIDTH / 8;
    localparam int unsigned SW  = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned MW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned SLW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        ERR
    } state_t;

    state_t          state, state_next;
    logic [MW-1:0]   owner, last_grant, pick;
    logic [SLW-1:0]  sel, dec_sel;
    logic [CW-1:0]   cnt;
    logic            dec_hit, found, timeout;
    int unsigned     idx;

    logic [ADDR_WIDTH-1:0] m_addr  [NUM_MASTERS];
    logic [BW-1:0]         m_be    [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] m_wdata [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] s_rdata [NUM_SLAVES];

    always_comb begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            m_addr[i]  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_be[i]    = m_be_i[i*BW +: BW];
            m_wdata[i] = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            s_rdata[s] = s_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Search starts one past the last completed owner, wrapping around.
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
            idx = (32'(last_grant) + k) % NUM_MASTERS;
            if (!found && m_req_i[MW'(idx)]) begin
                found = 1'b1;
                pick  = MW'(idx);
            end
        end
    end

    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            if (!dec_hit && m_addr[pick][SEL_MSB:SEL_LSB] == SLAVE_BASES[s*SW +: SW]) begin
                dec_hit = 1'b1;
                dec_sel = SLW'(s);
            end
        end
    end

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES));

    always_comb begin
        state_next = state;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        m_err_o    = 1'b0;
        s_req_o    = '0;
        s_addr_o   = '0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_wdata_o  = '0;
        busy_o     = (state != IDLE);
        case (state)
            IDLE: begin
                if (|m_req_i) state_next = dec_hit ? ADDR : ERR;
            end
            ADDR: begin
                s_req_o[sel]   = m_req_i[owner];
                s_addr_o       = m_addr[owner];
                s_we_o         = m_we_i[owner];
                s_be_o         = m_be[owner];
                s_wdata_o      = m_wdata[owner];
                m_gnt_o[owner] = s_gnt_i[sel];
                if (m_req_i[owner] && s_gnt_i[sel]) state_next = RESP;
                else if (!m_req_i[owner])           state_next = IDLE;
            end
            RESP: begin
                if (s_rvalid_i[sel]) begin
                    m_rvalid_o[owner] = 1'b1;
                    m_rdata_o         = s_rdata[sel];
                    state_next        = IDLE;
                end else if (timeout) begin
                    m_rvalid_o[owner] = 1'b1;
                    m_err_o           = 1'b1;
                    state_next        = IDLE;
                end else begin
                    m_rdata_o = s_rdata[sel];
                end
            end
            ERR: begin
                // The counter doubles as the grant/response phase marker here.
                if (cnt == '0) begin
                    m_gnt_o[owner] = 1'b1;
                end else begin
                    m_rvalid_o[owner] = 1'b1;
                    m_err_o           = 1'b1;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            owner      <= '0;
            sel        <= '0;
            last_grant <= MW'(NUM_MASTERS - 1);
            cnt        <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (|m_req_i) begin
                        owner <= pick;
                        sel   <= dec_sel;
                        cnt   <= '0;
                    end
                end
                ADDR: cnt <= '0;
                RESP: begin
                    if (state_next == IDLE) last_grant <= owner;
                    if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + CW'(1);
                end
                ERR: begin
                    cnt <= CW'(1);
                    if (state_next == IDLE) last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_obi_interconnect.sv
// Bench for obi_interconnect: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_obi_interconnect;

    localparam int NM = 3;
    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [7:0] BASES [NS] = '{8'h00, 8'h10, 8'h0A, 8'hF0};

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic [NM-1:0]   m_req_i = '0;
    logic [NM-1:0]   m_gnt_o;
    logic [NM*32-1:0] m_addr_i = '0;
    logic [NM-1:0]   m_we_i = '0;
    logic [NM*4-1:0] m_be_i = '0;
    logic [NM*32-1:0] m_wdata_i = '0;
    logic [NM-1:0]   m_rvalid_o;
    logic [31:0]     m_rdata_o;
    logic            m_err_o;
    logic [NS-1:0]   s_req_o;
    logic [NS-1:0]   s_gnt_i = '0;
    logic [31:0]     s_addr_o;
    logic            s_we_o;
    logic [3:0]      s_be_o;
    logic [31:0]     s_wdata_o;
    logic [NS-1:0]   s_rvalid_i = '0;
    logic [NS*32-1:0] s_rdata_i = '0;
    logic            busy_o;

    int checks = 0;
    int errors = 0;
    logic [NM-1:0] gnt_seen = '0;

    obi_interconnect #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .SEL_MSB(31), .SEL_LSB(24),
        .SLAVE_BASES({8'hF0, 8'h0A, 8'h10, 8'h00}),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
        .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o),
        .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [NM-1:0] req, input int last);
        for (int k = 1; k <= NM; k++)
            if (req[(last + k) % NM]) return (last + k) % NM;
        return -1;
    endfunction

    function automatic int decode(input logic [31:0] a);
        for (int s = 0; s < NS; s++)
            if (a[31:24] == BASES[s]) return s;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_master(input int i, input logic [31:0] a, input logic we, input logic [31:0] wd);
        m_addr_i[i*32 +: 32]  = a;
        m_we_i[i]             = we;
        m_be_i[i*4 +: 4]      = 4'hF;
        m_wdata_i[i*32 +: 32] = wd;
    endtask

    task automatic new_req(input int i);
        logic [7:0] top;
        case ($urandom_range(0, 5))
            0: top = 8'h00;
            1: top = 8'h10;
            2: top = 8'h0A;
            3: top = 8'hF0;
            4: top = 8'h50;
            default: top = 8'($urandom);
        endcase
        m_req_i[i]            = 1'b1;
        m_addr_i[i*32 +: 32]  = {top, 24'($urandom)};
        m_we_i[i]             = 1'($urandom);
        m_be_i[i*4 +: 4]      = 4'($urandom);
        m_wdata_i[i*32 +: 32] = $urandom;
    endtask

    // Model: phase 0 idle, 1 address, 2 response wait, 3 error grant, 4 error response.
    int mph = 0, mown = 0, mtgt = 0, mcnt = 0, mlast = NM - 1;

    always @(negedge clk) begin
        logic [NM-1:0] e_gnt, e_rv;
        logic [NS-1:0] e_sreq;
        logic [31:0]   e_rd, e_addr, e_wd;
        logic [3:0]    e_be;
        logic          e_we, e_err, cpay, crd;
        gnt_seen = m_gnt_o;
        e_gnt = '0; e_rv = '0; e_sreq = '0; e_rd = '0; e_addr = '0; e_wd = '0;
        e_be = '0; e_we = 1'b0; e_err = 1'b0; cpay = 1'b0; crd = 1'b0;
        if (!rst_ni) begin
            mph = 0; mlast = NM - 1; mcnt = 0;
        end
        if (mph == 0) begin
            cpay = 1'b1;
            crd  = 1'b1;
        end else if (mph == 1) begin
            e_sreq[mtgt] = m_req_i[mown];
            e_gnt[mown]  = s_gnt_i[mtgt];
            e_addr = m_addr_i[mown*32 +: 32];
            e_we   = m_we_i[mown];
            e_be   = m_be_i[mown*4 +: 4];
            e_wd   = m_wdata_i[mown*32 +: 32];
            cpay   = 1'b1;
        end else if (mph == 2) begin
            if (s_rvalid_i[mtgt]) begin
                e_rv[mown] = 1'b1;
                e_rd = s_rdata_i[mtgt*32 +: 32];
                crd  = 1'b1;
            end else if (mcnt == TO) begin
                e_rv[mown] = 1'b1;
                e_err = 1'b1;
                crd   = 1'b1;
            end
        end else if (mph == 3) begin
            e_gnt[mown] = 1'b1;
        end else begin
            e_rv[mown] = 1'b1;
            e_err = 1'b1;
            crd   = 1'b1;
        end
        chk("m_gnt", 64'(m_gnt_o), 64'(e_gnt));
        chk("m_rvalid", 64'(m_rvalid_o), 64'(e_rv));
        chk("m_err", 64'(m_err_o), 64'(e_err));
        chk("s_req", 64'(s_req_o), 64'(e_sreq));
        chk("busy", 64'(busy_o), 64'(mph != 0));
        if (cpay) begin
            chk("s_addr", 64'(s_addr_o), 64'(e_addr));
            chk("s_we", 64'(s_we_o), 64'(e_we));
            chk("s_be", 64'(s_be_o), 64'(e_be));
            chk("s_wdata", 64'(s_wdata_o), 64'(e_wd));
        end
        if (crd) chk("m_rdata", 64'(m_rdata_o), 64'(e_rd));
        if (rst_ni) begin
            case (mph)
                0: if (m_req_i != '0) begin
                    mown = rr(m_req_i, mlast);
                    mtgt = decode(m_addr_i[mown*32 +: 32]);
                    mph  = (mtgt >= 0) ? 1 : 3;
                end
                1: if (m_req_i[mown] && s_gnt_i[mtgt]) begin
                    mph = 2; mcnt = 0;
                end else if (!m_req_i[mown]) begin
                    mph = 0;
                end
                2: if (s_rvalid_i[mtgt] || mcnt == TO) begin
                    mph = 0; mlast = mown;
                end else begin
                    mcnt++;
                end
                3: mph = 4;
                default: begin mph = 0; mlast = mown; end
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_m, got;
        chk("model_rr_wrap", 64'(rr(3'b011, 1)), 64'd0);
        chk("model_rr_skip", 64'(rr(3'b100, 0)), 64'd2);
        chk("model_dec_hit", 64'(decode(32'hF000_0004)), 64'd3);
        chk("model_dec_miss", 64'(decode(32'h5000_0000)), 64'hFFFF_FFFF_FFFF_FFFF);
        for (int s = 0; s < NS; s++) s_rdata_i[s*32 +: 32] = 32'hDEAD_BE00 + 32'(s);

        sample(); sample();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_gnt", 64'(m_gnt_o), 64'd0);
        step(); rst_ni = 1'b1;

        // Single read, slave 0 grants immediately
        step(); m_req_i = 3'b001; set_master(0, 32'h0000_0010, 1'b0, 32'h0); s_gnt_i = 4'b0001;
        sample(); chk("sr_c0_gnt", 64'(m_gnt_o), 64'd0);
        sample(); chk("sr_c1_gnt", 64'(m_gnt_o), 64'b001);
        chk("sr_c1_sreq", 64'(s_req_o), 64'b0001);
        chk("sr_c1_addr", 64'(s_addr_o), 64'h10);
        step(); m_req_i = '0; s_rvalid_i = 4'b0001; s_rdata_i[31:0] = 32'h1234_5678;
        sample(); chk("sr_c2_rvalid", 64'(m_rvalid_o), 64'b001);
        chk("sr_c2_rdata", 64'(m_rdata_o), 64'h1234_5678);
        chk("sr_c2_err", 64'(m_err_o), 64'd0);
        step(); s_rvalid_i = '0;
        sample(); chk("sr_idle", 64'(busy_o), 64'd0);

        // Round robin between masters 0 and 1, last owner was 0
        step(); m_req_i = 3'b011; set_master(0, 32'h10, 1'b0, 0); set_master(1, 32'h20, 1'b0, 0);
        s_gnt_i = '1; s_rvalid_i = '1;
        exp_m = 1; got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            sample();
            if (m_gnt_o != '0) begin
                chk("rr_grant", 64'(m_gnt_o), 64'(1 << exp_m));
                exp_m = 1 - exp_m;
                got++;
            end
        end
        chk("rr_count", 64'(got), 64'd8);
        step(); m_req_i = '0;
        step(); s_gnt_i = '1; s_rvalid_i = '1;
        sample(); chk("rr_idle", 64'(busy_o), 64'd0);

        // Decode of writes
        step(); m_req_i = 3'b001; set_master(0, 32'h0A00_0000, 1'b1, 32'hCAFE);
        sample(); sample();
        chk("dec_a_sreq", 64'(s_req_o), 64'b0100);
        chk("dec_a_wdata", 64'(s_wdata_o), 64'hCAFE);
        chk("dec_a_we", 64'(s_we_o), 64'd1);
        step(); set_master(0, 32'hF000_0004, 1'b1, 32'hCAFE);
        sample(); chk("dec_a_rvalid", 64'(m_rvalid_o), 64'b001);
        step(); sample(); sample();
        chk("dec_b_sreq", 64'(s_req_o), 64'b1000);
        chk("dec_b_wdata", 64'(s_wdata_o), 64'hCAFE);
        chk("dec_b_addr", 64'(s_addr_o), 64'hF000_0004);
        step(); m_req_i = '0; m_we_i = '0;
        step(); sample(); chk("dec_idle", 64'(busy_o), 64'd0);

        // Unmapped read
        step(); m_req_i = 3'b001; set_master(0, 32'h5000_0000, 1'b0, 0);
        sample(); sample();
        chk("um_sreq", 64'(s_req_o), 64'd0);
        chk("um_gnt", 64'(m_gnt_o), 64'b001);
        chk("um_c1_rvalid", 64'(m_rvalid_o), 64'd0);
        step(); m_req_i = '0;
        sample();
        chk("um_rvalid", 64'(m_rvalid_o), 64'b001);
        chk("um_err", 64'(m_err_o), 64'd1);
        chk("um_rdata", 64'(m_rdata_o), 64'd0);
        chk("um_c2_sreq", 64'(s_req_o), 64'd0);
        step(); s_rvalid_i = '0;

        // Timeout: slave 2 grants but stays silent
        step(); m_req_i = 3'b001; set_master(0, 32'h0A00_0100, 1'b0, 0);
        sample(); sample(); chk("to_gnt", 64'(m_gnt_o), 64'b001);
        step(); m_req_i = '0;
        for (int k = 0; k < TO; k++) begin
            if (k > 0) sample();
            else @(negedge clk);
            chk("to_wait_rvalid", 64'(m_rvalid_o), 64'd0);
        end
        sample();
        chk("to_rvalid", 64'(m_rvalid_o), 64'b001);
        chk("to_err", 64'(m_err_o), 64'd1);
        chk("to_rdata", 64'(m_rdata_o), 64'd0);
        step(); s_rvalid_i = 4'b0100;
        sample(); chk("to_late_dropped", 64'(m_rvalid_o), 64'd0);
        step(); s_rvalid_i = '0; m_req_i = 3'b001; set_master(0, 32'h0A00_0000, 1'b0, 0);
        sample(); sample();
        step(); m_req_i = '0; s_rvalid_i = 4'b0100; s_rdata_i[2*32 +: 32] = 32'h55AA_55AA;
        sample();
        chk("to_next_rvalid", 64'(m_rvalid_o), 64'b001);
        chk("to_next_err", 64'(m_err_o), 64'd0);
        chk("to_next_rdata", 64'(m_rdata_o), 64'h55AA_55AA);
        step(); s_rvalid_i = '0;

        // Reset asserted during a response from master 1
        step(); m_req_i = 3'b010; set_master(1, 32'h0000_0040, 1'b0, 0);
        sample(); sample();
        step(); m_req_i = '0; s_rvalid_i = 4'b0001;
        #1 chk("rst_pre_rvalid", 64'(m_rvalid_o), 64'b010);
        rst_ni = 1'b0;
        #1;
        chk("rst_async_rvalid", 64'(m_rvalid_o), 64'd0);
        chk("rst_async_rdata", 64'(m_rdata_o), 64'd0);
        chk("rst_async_busy", 64'(busy_o), 64'd0);
        chk("rst_async_sreq", 64'(s_req_o), 64'd0);
        chk("rst_async_pay", 64'({s_addr_o, s_wdata_o}), 64'd0);
        sample();
        step(); rst_ni = 1'b1; m_req_i = 3'b011; s_rvalid_i = '0;
        set_master(0, 32'h10, 1'b0, 0); set_master(1, 32'h20, 1'b0, 0);
        sample(); sample(); chk("rst_first_winner", 64'(m_gnt_o), 64'b001);
        step(); m_req_i = '0; s_rvalid_i = '1;
        step(); s_rvalid_i = '0;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int i = 0; i < NM; i++) begin
                if (m_req_i[i]) begin
                    if (gnt_seen[i]) begin
                        if ($urandom_range(0, 1) == 1) new_req(i);
                        else m_req_i[i] = 1'b0;
                    end else if ($urandom_range(0, 31) == 0) begin
                        m_req_i[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i);
                end
            end
            for (int s = 0; s < NS; s++) begin
                s_gnt_i[s]    = ($urandom_range(0, 9) < 6);
                s_rvalid_i[s] = (s == 3) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 1) == 1);
                s_rdata_i[s*32 +: 32] = $urandom;
            end
        end
        step(); m_req_i = '0;
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
